// File: rtl/xpb_accum_seq_pkg.sv
// ---------------------------------------------------------------------------
// xpb_accum_seq_pkg
//
// Shared constants and types for the xpb reduction accumulator.
//   WORD_BITS : modulus word width (in_lo and each xpb constant)
//   SEG_BITS  : width of one upper segment, equal to the xpb LUT select width
//   NUM_SEGS  : number of upper segments folded in per operation
//   IDX_BITS  : width of the segment index that selects the LUT bank
//   ACC_BITS  : accumulator width; the guard bits hold up to NUM_SEGS+1 words
//   HI_BITS   : total width of the upper part of the product
// ---------------------------------------------------------------------------
package xpb_accum_seq_pkg;

    localparam int WORD_BITS = 1024;
    localparam int SEG_BITS  = 5;
    localparam int NUM_SEGS  = 8;
    localparam int IDX_BITS  = $clog2(NUM_SEGS);
    localparam int ACC_BITS  = WORD_BITS + $clog2(NUM_SEGS + 1);
    localparam int HI_BITS   = NUM_SEGS * SEG_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } xpb_acc_state_t;

endpackage

// File: rtl/xpb_accum_seq.sv
// ---------------------------------------------------------------------------
// xpb_accum_seq
//
// Sequential reduction accumulator. Takes one partially reduced product
// (in_lo + upper segments in_hi), walks the upper segments one per cycle,
// asks the external xpb LUT bank for x*2^k mod p of each segment and adds the
// returned constant into a guard-bit accumulator. The unreduced sum is handed
// on through a valid/ready handshake.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand valid
//   in_ready     out  operand can be accepted (IDLE only)
//   in_lo        in   low product word, initial accumulator value
//   in_hi        in   upper segments, segment i at [i*SEG_BITS +: SEG_BITS]
//   lut_seg_idx  out  segment position, selects the LUT bank (0 outside ACCUM)
//   lut_sel      out  segment value, LUT address (0 outside ACCUM)
//   lut_xpb      in   combinational LUT result for (lut_seg_idx, lut_sel)
//   out_valid    out  result valid, held until out_ready
//   out_ready    in   consumer accepts the result
//   out_sum      out  accumulated sum
//   busy         out  high while in ACCUM or DONE
// ---------------------------------------------------------------------------
module xpb_accum_seq
    import xpb_accum_seq_pkg::*;
#(
    parameter int P_WORD_BITS = WORD_BITS,
    parameter int P_SEG_BITS  = SEG_BITS,
    parameter int P_NUM_SEGS  = NUM_SEGS,
    parameter int P_IDX_BITS  = IDX_BITS,
    parameter int P_ACC_BITS  = ACC_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [P_WORD_BITS-1:0]           in_lo,
    input  logic [P_NUM_SEGS*P_SEG_BITS-1:0] in_hi,
    output logic [P_IDX_BITS-1:0]            lut_seg_idx,
    output logic [P_SEG_BITS-1:0]            lut_sel,
    input  logic [P_WORD_BITS-1:0]           lut_xpb,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [P_ACC_BITS-1:0]            out_sum,
    output logic                             busy
);

    localparam int P_HI_BITS = P_NUM_SEGS * P_SEG_BITS;
    localparam int P_GUARD   = P_ACC_BITS - P_WORD_BITS;
    localparam logic [P_IDX_BITS-1:0] LAST_IDX = P_IDX_BITS'(P_NUM_SEGS - 1);

    xpb_acc_state_t          state_q;
    logic [P_ACC_BITS-1:0]   acc_q;
    logic [P_HI_BITS-1:0]    hi_sh_q;
    logic [P_IDX_BITS-1:0]   cnt_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic [P_ACC_BITS-1:0]   acc_d;
    logic [P_HI_BITS-1:0]    hi_sh_d;
    logic                    in_accum;

    // Datapath next values: one wide adder and the segment shifter. The LUT
    // result is consumed on the same edge the segment is presented, so the
    // LUT read sits inside this single-cycle path.
    always_comb begin
        in_accum = (state_q == ACCUM);
        acc_d    = acc_q + {{P_GUARD{1'b0}}, lut_xpb};
        hi_sh_d  = hi_sh_q >> P_SEG_BITS;
    end

    // The LUT address lines are forced to zero outside ACCUM so the LUT bank
    // sees a quiet, deterministic address while the block is idle or waiting.
    assign lut_seg_idx = in_accum ? cnt_q : '0;
    assign lut_sel     = in_accum ? hi_sh_q[P_SEG_BITS-1:0] : '0;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = acc_q;

    // Control FSM and datapath registers. The handshake flags are registered
    // alongside the state so they change exactly with the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            hi_sh_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= {{P_GUARD{1'b0}}, in_lo};
                        hi_sh_q    <= in_hi;
                        cnt_q      <= '0;
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    // Zero segments still take their cycle, keeping the
                    // operation length fixed and data-independent.
                    acc_q   <= acc_d;
                    hi_sh_q <= hi_sh_d;
                    cnt_q   <= cnt_q + P_IDX_BITS'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Result held stable until taken; IDLE is always visited
                    // for at least one cycle before the next operand.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_xpb_accum_seq
//
// Scoreboard bench for xpb_accum_seq. Stimulus pushes the hand-computed
// expected sum when an operand is accepted; a monitor pops and compares on
// every output handshake. The LUT model returns 0 for a zero segment,
// seg_idx*32 + sel otherwise, or all ones in saturation mode.
// ---------------------------------------------------------------------------
module tb_xpb_accum_seq;

    localparam int WB = 1024;
    localparam int AB = 1028;
    localparam int HB = 40;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WB-1:0] in_lo;
    logic [HB-1:0] in_hi;
    logic [2:0]    lut_seg_idx;
    logic [4:0]    lut_sel;
    logic [WB-1:0] lut_xpb;
    logic          out_valid;
    logic          out_ready;
    logic [AB-1:0] out_sum;
    logic          busy;

    logic          sat_mode;
    int            errors;
    int            checks;
    int            cyc;
    logic [AB-1:0] exp_q[$];

    xpb_accum_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lo       (in_lo),
        .in_hi       (in_hi),
        .lut_seg_idx (lut_seg_idx),
        .lut_sel     (lut_sel),
        .lut_xpb     (lut_xpb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LUT model
    always_comb begin
        if (sat_mode)
            lut_xpb = '1;
        else if (lut_sel == 5'd0)
            lut_xpb = '0;
        else
            lut_xpb = WB'({lut_seg_idx, 5'b0}) + WB'(lut_sel);
    end

    task automatic chk(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got top=%h low=%h, need top=%h low=%h",
                     name, act[AB-1:AB-36], act[63:0], exp[AB-1:AB-36], exp[63:0]);
        end else begin
            $display("ok   %s: top=%h low=%h", name, act[AB-1:AB-36], act[63:0]);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum low=%h, need no output", out_sum[63:0]);
            end else begin
                chk("scoreboard_sum", out_sum, exp_q.pop_front());
            end
        end
    end

    // Present an operand (called #1 after a posedge) and return #1 after the
    // accepting edge; acc_cyc is the cycle number of that edge.
    task automatic send(input logic [WB-1:0] lo, input logic [HB-1:0] hi,
                        input logic [AB-1:0] exp, input bit push,
                        input bit keep_valid, output int acc_cyc);
        int n;
        in_lo    = lo;
        in_hi    = hi;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", AB'(n), AB'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (push) exp_q.push_back(exp);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(in_ready && exp_q.size() == 0)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 60) begin
                chk("drain_timeout", AB'(n), AB'(0));
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  AB'(in_ready),    AB'(1));
        chk({tag, "_out_valid"}, AB'(out_valid),   AB'(0));
        chk({tag, "_out_sum"},   out_sum,          AB'(0));
        chk({tag, "_busy"},      AB'(busy),        AB'(0));
        chk({tag, "_seg_idx"},   AB'(lut_seg_idx), AB'(0));
        chk({tag, "_sel"},       AB'(lut_sel),     AB'(0));
    endtask

    initial begin
        int n;
        int c0, c1, c2;
        logic [AB-1:0] sat_exp;

        errors    = 0;
        checks    = 0;
        cyc       = 0;
        sat_mode  = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_lo     = '0;
        in_hi     = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");

        // Zero upper part, latency 8 edges
        @(posedge clk); #1;
        send(WB'(5), '0, AB'(5), 1'b1, 1'b0, c0);
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid || n >= 20) break;
        end
        chk("zero_latency", AB'(n), AB'(8));
        wait_drain();

        // All segments 31: sum 1144, index walks 0..7
        send('0, {8{5'd31}}, AB'(1144), 1'b1, 1'b0, c0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("seg_idx_%0d", k), AB'(lut_seg_idx), AB'(k));
            chk($sformatf("seg_sel_%0d", k), AB'(lut_sel), AB'(31));
        end
        wait_drain();

        // Saturation: 9*(2^1024-1), no wrap
        sat_mode = 1'b1;
        sat_exp  = {4'h8, {1020{1'b1}}, 4'h7};
        send('1, 40'h12_3456_789A, sat_exp, 1'b1, 1'b0, c0);
        wait_drain();
        sat_mode = 1'b0;

        // Back-pressure: 100 + 1 + (32+2) = 135
        out_ready = 1'b0;
        send(WB'(100), 40'h41, AB'(135), 1'b1, 1'b0, c0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_lo    = WB'(9);
        in_hi    = '0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_sum_%0d", k),      out_sum,         AB'(135));
            chk($sformatf("bp_valid_%0d", k),    AB'(out_valid),  AB'(1));
            chk($sformatf("bp_in_ready_%0d", k), AB'(in_ready),   AB'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);          // output handshake edge
        #1;
        @(negedge clk);
        chk("bp_idle_after_hs", AB'(busy), AB'(0));
        chk("bp_ready_after_hs", AB'(in_ready), AB'(1));
        @(posedge clk);          // operand accepted here
        #1;
        exp_q.push_back(AB'(9));
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_accepted", AB'(busy), AB'(1));
        wait_drain();

        // Reset mid-ACCUM at cnt=3; discarded result
        send(WB'(50), {8{5'd31}}, '0, 1'b0, 1'b0, c0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_cnt3_idx", AB'(lut_seg_idx), AB'(3));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", AB'(in_ready), AB'(1));
        @(posedge clk); #1;
        send(WB'(7), '0, AB'(7), 1'b1, 1'b0, c0);
        wait_drain();

        // Back-to-back: 1+1+33=35, 2+(7*32+3)=229, 1000
        send(WB'(1), 40'h21, AB'(35), 1'b1, 1'b1, c0);
        send(WB'(2), {5'd3, 35'd0}, AB'(229), 1'b1, 1'b1, c1);
        send(WB'(1000), '0, AB'(1000), 1'b1, 1'b0, c2);
        chk("b2b_spacing_1", AB'(c1 - c0), AB'(10));
        chk("b2b_spacing_2", AB'(c2 - c1), AB'(10));
        wait_drain();

        chk("scoreboard_empty", AB'(exp_q.size()), AB'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, need finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xpb_accum_seq.md
# xpb_accum_seq

Sequential reduction accumulator that consumes the precomputed `x*2^k mod p` (xpb) constants produced by the per-segment xpb lookup tables in the modular-squaring datapath. It takes one partially reduced product and walks its upper part one 5-bit segment per cycle. For each segment it drives the segment index and value to the external xpb LUT bank and adds the returned 1024-bit constant into a guard-bit accumulator. The finished, not-fully-reduced sum goes to the next squaring iteration through a valid/ready handshake.

## Interface
Parameters:
- `WORD_BITS`, 1024, modulus-width word; width of `in_lo` and of each xpb constant.
- `SEG_BITS`, 5, segment width; matches the xpb LUT select width.
- `NUM_SEGS`, 8, number of upper segments reduced per operation.
- `IDX_BITS`, 3, `clog2(NUM_SEGS)`.
- `ACC_BITS`, 1028, `WORD_BITS + clog2(NUM_SEGS+1)`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand.
- `in_lo`  in  WORD_BITS  low part of the product, the initial accumulator value.
- `in_hi`  in  NUM_SEGS*SEG_BITS  upper segments; segment i is `in_hi[i*SEG_BITS +: SEG_BITS]`.
- `lut_seg_idx`  out  IDX_BITS  segment position, which selects the LUT bank.
- `lut_sel`  out  SEG_BITS  segment value, the LUT address.
- `lut_xpb`  in  WORD_BITS  combinational LUT result for (`lut_seg_idx`, `lut_sel`).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_BITS  accumulated sum.
- `busy`  out  1  high in ACCUM or DONE.

## Operation
- State machine has three states: IDLE, ACCUM and DONE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid & in_ready`: `acc <= {guard 0s, in_lo}`, `hi_sh <= in_hi`, `cnt <= 0`, state becomes ACCUM.
- **ACCUM:**
  - Combinational outputs: `lut_seg_idx = cnt`, `lut_sel = hi_sh[SEG_BITS-1:0]`.
  - Each cycle: `acc <= acc + zero_extend(lut_xpb)`, `hi_sh <= hi_sh >> SEG_BITS`, `cnt <= cnt+1`.
  - When `cnt == NUM_SEGS-1` the state becomes DONE.
- **DONE:**
  - `out_valid=1` and `out_sum=acc`, held stable until `out_ready`.
  - On `out_valid & out_ready` the state becomes IDLE.
- A segment value of 0 is still processed. The LUT returns 0, so the cycle count is fixed and data-independent.
- Arithmetic is unsigned. ACC_BITS guarantees no overflow: the maximum is `(NUM_SEGS+1)*(2^WORD_BITS-1)`. No modular correction is done here.
- `lut_seg_idx` and `lut_sel` are 0 outside ACCUM.
- `in_valid` is ignored outside IDLE.

## Timing
- Reset values: state IDLE; `acc`, `hi_sh` and `cnt` are 0; `in_ready=1`, `out_valid=0`, `out_sum=0`, `busy=0`, `lut_seg_idx=0`, `lut_sel=0`.
- Latency: input handshake at edge E gives `out_valid` high after edge E+NUM_SEGS (8 cycles).
- Minimum throughput is one operation per NUM_SEGS+2 cycles. The input handshake happens in IDLE only, and IDLE is always entered for at least one cycle after the output handshake.
- `lut_xpb` is sampled on the same edge that `lut_sel` is presented. This is a single-cycle combinational LUT path, and the LUT must meet timing within that cycle.
- Reset asserted mid-operation clears everything immediately. The partial result is discarded, no `out_valid` is produced, and `in_ready=1` on the first edge after release.
- `out_ready` held low in DONE leaves `out_sum` unchanged indefinitely.

## Structure
- The shared package holds `WORD_BITS`, `SEG_BITS`, `NUM_SEGS`, `ACC_BITS`, and a state enum `xpb_acc_state_t` {IDLE, ACCUM, DONE}.
- One natural sub-module is `xpb_lut_bank`. It instantiates the per-position xpb tables and muxes them by `lut_seg_idx`. It sits outside this block and connects through the `lut_*` ports, so the bench can substitute a model.
- The core is a single module: FSM, counter, shift register, and one ACC_BITS adder.

## Test plan
The bench LUT model returns `lut_xpb = lut_seg_idx*32 + lut_sel`, except in the saturation case.
- Zero upper part: `in_lo=5`, `in_hi=0` -> `out_sum=5`, with `out_valid` rising exactly 8 cycles after the handshake.
- All segments at 31: `in_lo=0`, every segment 31 -> `out_sum = sum over i=0..7 of (32i+31) = 1144`; the bench checks `lut_seg_idx` steps 0..7.
- Saturation: model returns all ones, `in_lo` all ones -> `out_sum = 0x8FF…FF7` (1028 bits, i.e. 9*(2^1024-1)), with no wrap.
- Back-pressure: `out_ready` low for 5 cycles in DONE -> `out_sum` and `out_valid` stable, `in_ready=0`; a new `in_valid` is not accepted until one cycle after the output handshake.
- Reset mid-ACCUM: pulse `rst_n` low at `cnt=3` -> all outputs at reset values; a following operation with `in_lo=7`, `in_hi=0` yields 7.
- Back-to-back: `in_valid` and `out_ready` held high -> handshakes every 10 cycles with correct independent sums.
